// File: rtl/dds_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_param_ctrl
// Purpose  : User-input front end of the DDS board. Synchronizes and
//            debounces four active-low push keys and maintains the waveform
//            parameters (waveform select, frequency in Hz, amplitude code)
//            that feed both the DDS core and the 7-segment display block.
//            A one-cycle strobe follows every actual parameter change.
// Ports    : clk        - system clock (50 MHz)
//            rst_n      - asynchronous active-low reset
//            key[3:0]   - raw active-low keys, asynchronous to clk
//                         [0] wave cycle, [1] freq up, [2] freq down,
//                         [3] amplitude cycle
//            wave_sel   - waveform select code 0..3
//            wave_freq  - output frequency in Hz
//            wave_a     - amplitude code 0..3
//            param_upd  - single-cycle pulse after any output value changes
// Options  : `define DDS_PARAM_CTRL_AUTO_REPEAT_EN to enable hold-to-repeat
//            on the frequency keys (adds REP_DLY / REP_PER parameters).
// Revision : 1.0 - initial release
// ============================================================================
module dds_param_ctrl #(
  parameter int DEB_CYC   = 1000000,
  parameter int FREQ_INIT = 500,
  parameter int FREQ_MIN  = 500,
  parameter int FREQ_MAX  = 999500,
`ifdef DDS_PARAM_CTRL_AUTO_REPEAT_EN
  parameter int FREQ_STEP = 500,
  parameter int REP_DLY   = 25000000,
  parameter int REP_PER   = 5000000
`else
  parameter int FREQ_STEP = 500
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key,
  output logic [1:0]  wave_sel,
  output logic [19:0] wave_freq,
  output logic [1:0]  wave_a,
  output logic        param_upd
);

  // Debounce counter only has to hold 0..DEB_CYC-1.
  localparam int DCW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  // Frequency arithmetic is done in 21 bits so that the up-step can be
  // checked against the ceiling without wrapping.
  localparam logic [20:0] C_STEP21     = 21'(FREQ_STEP);
  localparam logic [20:0] C_MAX21      = 21'(FREQ_MAX);
  localparam logic [20:0] C_DN_LIMIT21 = 21'(FREQ_MIN + FREQ_STEP);
  localparam logic [19:0] C_STEP       = 20'(FREQ_STEP);
  localparam logic [19:0] C_MIN        = 20'(FREQ_MIN);
  localparam logic [19:0] C_MAX        = 20'(FREQ_MAX);
  localparam logic [19:0] C_INIT       = 20'(FREQ_INIT);

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; released (high) level during reset.
  // --------------------------------------------------------------------------
  logic [3:0] key_meta_q;
  logic [3:0] key_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
    end else begin
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Per-key debounce. The stable level follows the synced level only after
  // DEB_CYC consecutive disagreeing samples; a single agreeing sample clears
  // the count. The press pulse is registered on the same edge the stable
  // level falls, so it is high during the following cycle.
  // --------------------------------------------------------------------------
  logic [3:0] stable_w;
  logic [3:0] press_w;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [DCW-1:0] cnt_q;
    logic           stable_q;
    logic           press_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b1;
        press_q  <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (key_sync_q[i] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DCW'(DEB_CYC - 1)) begin
          cnt_q    <= '0;
          stable_q <= key_sync_q[i];
          // Only the 1->0 transition is a press; releases are ignored.
          press_q  <= ~key_sync_q[i];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign stable_w[i] = stable_q;
    assign press_w[i]  = press_q;
  end

  // --------------------------------------------------------------------------
  // Event vector: presses, plus hold-to-repeat events on the frequency keys
  // when the option is built in.
  // --------------------------------------------------------------------------
  logic [3:0] ev_w;

`ifdef DDS_PARAM_CTRL_AUTO_REPEAT_EN
  localparam int HMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  logic [2:1] rep_w;

  // First repeat after REP_DLY cycles of stable hold, then every REP_PER.
  // phase_q distinguishes the initial delay from the periodic interval.
  for (genvar i = 1; i < 3; i++) begin : g_rep
    logic [HW-1:0] hold_q;
    logic          phase_q;
    logic          rep_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q  <= '0;
        phase_q <= 1'b0;
        rep_q   <= 1'b0;
      end else if (stable_w[i]) begin
        hold_q  <= '0;
        phase_q <= 1'b0;
        rep_q   <= 1'b0;
      end else if ((!phase_q && hold_q == HW'(REP_DLY - 1)) ||
                   ( phase_q && hold_q == HW'(REP_PER - 1))) begin
        hold_q  <= '0;
        phase_q <= 1'b1;
        rep_q   <= 1'b1;
      end else begin
        hold_q  <= hold_q + 1'b1;
        rep_q   <= 1'b0;
      end
    end

    assign rep_w[i] = rep_q;
  end

  assign ev_w = press_w | {1'b0, rep_w, 1'b0};
`else
  // Stable levels are only consumed by the repeat logic.
  logic unused_stable_w;
  assign unused_stable_w = ^stable_w;
  assign ev_w = press_w;
`endif

  // --------------------------------------------------------------------------
  // Parameter registers
  // --------------------------------------------------------------------------
  logic [1:0]  sel_q,  sel_d;
  logic [19:0] freq_q, freq_d;
  logic [1:0]  amp_q,  amp_d;
  logic        upd_q;

  logic [20:0] freq_up21_w;
  logic [19:0] freq_up_w;
  logic [19:0] freq_dn_w;
  logic        changed_w;

  assign freq_up21_w = {1'b0, freq_q} + C_STEP21;
  assign freq_up_w   = (freq_up21_w > C_MAX21) ? C_MAX : freq_up21_w[19:0];
  // Compare before subtracting so the result can never wrap below zero.
  assign freq_dn_w   = ({1'b0, freq_q} >= C_DN_LIMIT21) ? (freq_q - C_STEP) : C_MIN;

  always_comb begin
    sel_d  = sel_q;
    amp_d  = amp_q;
    freq_d = freq_q;
    if (ev_w[0]) begin
      sel_d = sel_q + 2'd1;
    end
    if (ev_w[3]) begin
      amp_d = amp_q + 2'd1;
    end
    // Up and down together cancel.
    if (ev_w[1] && !ev_w[2]) begin
      freq_d = freq_up_w;
    end else if (ev_w[2] && !ev_w[1]) begin
      freq_d = freq_dn_w;
    end
  end

  // Saturated steps leave the value unchanged and therefore raise no strobe.
  assign changed_w = (sel_d != sel_q) || (amp_d != amp_q) || (freq_d != freq_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 2'd0;
      freq_q <= C_INIT;
      amp_q  <= 2'd0;
      upd_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      freq_q <= freq_d;
      amp_q  <= amp_d;
      upd_q  <= changed_w;
    end
  end

  assign wave_sel  = sel_q;
  assign wave_freq = freq_q;
  assign wave_a    = amp_q;
  assign param_upd = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_param_ctrl
// Purpose  : Self-checking bench for dds_param_ctrl with a short debounce.
//            Expected parameter sets are queued when a key action is driven
//            and popped whenever the DUT raises param_upd.
// Ports    : none
// Options  : DDS_PARAM_CTRL_AUTO_REPEAT_EN adds the hold-to-repeat checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_param_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 500;
  localparam int FMIN = 500;
  localparam int FMAX = 999500;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  key   = 4'hF;
  logic [1:0]  wave_sel;
  logic [19:0] wave_freq;
  logic [1:0]  wave_a;
  logic        param_upd;

  dds_param_ctrl #(
    .DEB_CYC   (DEB),
    .FREQ_INIT (500),
    .FREQ_MIN  (FMIN),
    .FREQ_MAX  (FMAX),
`ifdef DDS_PARAM_CTRL_AUTO_REPEAT_EN
    .FREQ_STEP (STEP),
    .REP_DLY   (20),
    .REP_PER   (8)
`else
    .FREQ_STEP (STEP)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .wave_sel  (wave_sel),
    .wave_freq (wave_freq),
    .wave_a    (wave_a),
    .param_upd (param_upd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [19:0] freq;
    logic [1:0]  amp;
  } exp_t;

  exp_t q[$];

  int n_cmp  = 0;
  int n_err  = 0;
  int pulses = 0;
  int cyc    = 0;

  logic [1:0]  m_sel  = 2'd0;
  logic [19:0] m_freq = 20'd500;
  logic [1:0]  m_amp  = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] f_up(input logic [19:0] f);
    int t;
    t = int'(f) + STEP;
    return (t > FMAX) ? 20'(FMAX) : 20'(t);
  endfunction

  function automatic logic [19:0] f_dn(input logic [19:0] f);
    int t;
    t = int'(f) - STEP;
    return (t < FMIN) ? 20'(FMIN) : 20'(t);
  endfunction

  task automatic push_exp();
    exp_t e;
    e.sel  = m_sel;
    e.freq = m_freq;
    e.amp  = m_amp;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_sel  = 2'd0;
    m_freq = 20'd500;
    m_amp  = 2'd0;
    q.delete();
  endtask

  // One clock; samples 1 ns after the edge and scores any update strobe.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 90000) begin
      n_err++;
      $display("FAIL timeout: observed cycle %0d required below 90000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (param_upd === 1'b1) begin
      pulses++;
      chk("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("upd_sel",  {30'd0, wave_sel},  {30'd0, e.sel});
        chk("upd_freq", {12'd0, wave_freq}, {12'd0, e.freq});
        chk("upd_amp",  {30'd0, wave_a},    {30'd0, e.amp});
      end
    end
  endtask

  // Press the keys in mask together, hold, release, and score the result.
  task automatic press(input logic [3:0] mask);
    logic [1:0]  ns;
    logic [19:0] nf;
    logic [1:0]  na;
    logic        chg;
    int          p0;
    ns = m_sel;
    nf = m_freq;
    na = m_amp;
    if (mask[0]) ns = ns + 2'd1;
    if (mask[3]) na = na + 2'd1;
    if (mask[1] && !mask[2]) nf = f_up(nf);
    if (mask[2] && !mask[1]) nf = f_dn(nf);
    chg = (ns != m_sel) || (nf != m_freq) || (na != m_amp);
    m_sel  = ns;
    m_freq = nf;
    m_amp  = na;
    if (chg) push_exp();
    p0  = pulses;
    key = ~mask;
    repeat (10) tick();
    key = 4'hF;
    repeat (10) tick();
    chk("press_pulses", pulses - p0, chg ? 32'd1 : 32'd0);
    chk("press_drained", q.size(), 32'd0);
  endtask

  initial begin
    int p0;

    // Reset state, checked while reset is asserted.
    rst_n = 1'b0;
    #1;
    chk("rst_sel",  {30'd0, wave_sel},  32'd0);
    chk("rst_freq", {12'd0, wave_freq}, 32'd500);
    chk("rst_amp",  {30'd0, wave_a},    32'd0);
    chk("rst_upd",  {31'd0, param_upd}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean freq-up press: result appears exactly 7 cycles after the edge.
    m_freq = f_up(m_freq);
    push_exp();
    p0 = pulses;
    key[1] = 1'b0;
    repeat (6) tick();
    chk("lat_before_freq", {12'd0, wave_freq}, 32'd500);
    tick();
    chk("lat_at7_freq",   {12'd0, wave_freq}, 32'd1000);
    chk("lat_at7_pulses", pulses - p0, 32'd1);
    key[1] = 1'b1;
    repeat (10) tick();
    chk("lat_pulse_once", pulses - p0, 32'd1);

    // Wave select and amplitude each cycle through 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      press(4'b0001);
      chk("sel_step", {30'd0, wave_sel}, {30'd0, m_sel});
    end
    for (int i = 0; i < 4; i++) begin
      press(4'b1000);
      chk("amp_step", {30'd0, wave_a}, {30'd0, m_amp});
    end

    // Up and down together cancel; the wave-cycle press still applies.
    press(4'b0111);
    chk("simul_freq", {12'd0, wave_freq}, 32'd1000);
    chk("simul_sel",  {30'd0, wave_sel},  32'd1);

    // Down to the floor, then down at the floor gives nothing.
    press(4'b0100);
    chk("down_freq", {12'd0, wave_freq}, 32'd500);
    press(4'b0100);
    chk("floor_freq", {12'd0, wave_freq}, 32'd500);

    // Bouncing up press: one increment, only after the final steady run.
    p0 = pulses;
    key[1] = 1'b0; tick(); tick();
    key[1] = 1'b1; tick();
    key[1] = 1'b0; tick(); tick();
    key[1] = 1'b1; tick();
    m_freq = f_up(m_freq);
    push_exp();
    key[1] = 1'b0;
    repeat (6) tick();
    chk("bounce_early", pulses - p0, 32'd0);
    tick();
    chk("bounce_at7", pulses - p0, 32'd1);
    repeat (5) tick();
    key[1] = 1'b1;
    repeat (10) tick();
    chk("bounce_pulses", pulses - p0, 32'd1);
    chk("bounce_freq", {12'd0, wave_freq}, 32'd1000);

    // Climb to the ceiling, then up at the ceiling gives nothing.
    for (int i = 0; i < 1997; i++) begin
      press(4'b0010);
    end
    chk("ceil_reached", {12'd0, wave_freq}, 32'd999500);
    press(4'b0010);
    chk("ceil_freq", {12'd0, wave_freq}, 32'd999500);

`ifdef DDS_PARAM_CTRL_AUTO_REPEAT_EN
    // Hold-to-repeat: steps at press, +20, +28, ..., +60.
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    m_freq = f_up(m_freq);
    push_exp();
    p0 = pulses;
    key[1] = 1'b0;
    repeat (7) tick();
    chk("rep_press", pulses - p0, 32'd1);
    for (int k = 0; k < 6; k++) begin
      m_freq = f_up(m_freq);
      push_exp();
      p0 = pulses;
      repeat (((k == 0) ? 20 : 8) - 1) tick();
      chk("rep_early", pulses - p0, 32'd0);
      tick();
      chk("rep_step", pulses - p0, 32'd1);
    end
    chk("rep_freq", {12'd0, wave_freq}, 32'd4000);

    // Reset mid-hold clears outputs at once and stops the repeats.
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_freq", {12'd0, wave_freq}, 32'd500);
    chk("mid_rst_sel",  {30'd0, wave_sel},  32'd0);
    chk("mid_rst_upd",  {31'd0, param_upd}, 32'd0);
    model_reset();
    key = 4'hF;
    repeat (3) tick();
    rst_n = 1'b1;
    p0 = pulses;
    repeat (40) tick();
    chk("rep_stopped", pulses - p0, 32'd0);
    chk("rep_stopped_freq", {12'd0, wave_freq}, 32'd500);
`endif

    chk("final_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_param_ctrl.md
Name: dds_param_ctrl

Overview:
- User-input front end of the DDS board: debounces four active-low push keys and maintains the waveform parameters.
- Parameters maintained: waveform select, output frequency in Hz, amplitude code.
- Drives wave_sel / wave_freq / wave_a into both the DDS core and the 7-segment display block; it is the producer side of that parameter interface.
- Emits a one-cycle update strobe whenever any parameter changes.

Parameters:
- DEB_CYC, 1000000, consecutive stable cycles required to accept a key level change (20 ms @ 50 MHz).
- FREQ_INIT, 500, wave_freq value after reset.
- FREQ_MIN, 500, lower saturation bound for wave_freq.
- FREQ_MAX, 999500, upper saturation bound for wave_freq (must fit 20 bits).
- FREQ_STEP, 500, increment/decrement per accepted press.
- REP_DLY, 25000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only).
- REP_PER, 5000000, auto-repeat interval (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- key  input  4  raw keys, active-low, asynchronous to clk; [0] wave cycle, [1] freq up, [2] freq down, [3] amplitude cycle
- wave_sel  output  2  waveform select code 0..3
- wave_freq  output  20  frequency in Hz
- wave_a  output  2  amplitude code 0..3
- param_upd  output  1  single-cycle pulse, high in the cycle after any output value changes

Behaviour:
- Reset (rst_n low, async): wave_sel=0, wave_freq=FREQ_INIT, wave_a=0, param_upd=0, synchronizers/stable levels=1 (released), debounce counters=0.
- Synchronizer: each key bit passes through a 2-flop synchronizer before any other use.
- Debounce, per key: if the synced level equals the stable level, counter=0. Otherwise the counter increments. When the counter reaches DEB_CYC-1, the stable level takes the synced level and the counter clears. Any bounce back clears the counter.
- Press event: stable level 1->0, registered as a 1-cycle pulse. Release events cause no action.
- Latency: the registered outputs update on the clock edge after the press-event cycle, and param_upd is high for the cycle following that edge. From a clean raw edge, outputs change after 2 (sync) + DEB_CYC + 1 cycles.
- key[0] press: wave_sel <= wave_sel+1, wrapping 3->0.
- key[3] press: wave_a <= wave_a+1, wrapping 3->0.
- key[1] press: wave_freq <= min(wave_freq+FREQ_STEP, FREQ_MAX). Compute in 21 bits; no overflow wrap.
- key[2] press: wave_freq <= max(wave_freq-FREQ_STEP, FREQ_MIN). Compare before subtracting; no underflow wrap.
- Simultaneous key[1] and key[2] press events in the same cycle: wave_freq unchanged.
- Events on different parameters in the same cycle all apply together; param_upd gives one pulse.
- param_upd asserts only if at least one output value actually changed. Up at FREQ_MAX or down at FREQ_MIN gives no pulse.
- Reset mid-debounce or mid-hold: everything returns to reset values immediately. A key still held at reset release is debounced as a new press.

Optional Feature:
- Macro: DDS_PARAM_CTRL_AUTO_REPEAT_EN.
- Defined: while key[1] or key[2] stays stably pressed, a hold counter runs. After REP_DLY cycles it generates a repeat event, then one every REP_PER cycles. A repeat event acts exactly like a press event, including saturation and param_upd rules. The counter clears on release or reset. Only the freq keys repeat.
- Undefined: no hold counter is synthesized; one press gives exactly one step.

Test Plan (DEB_CYC=4, REP_DLY=20, REP_PER=8, FREQ_STEP=500):
- Reset, no keys -> wave_sel=0, wave_freq=500, wave_a=0, param_upd=0. Then clean press of key[1] -> wave_freq=1000 exactly 7 cycles after the raw falling edge, one param_upd pulse.
- key[0] pressed and released 4 times -> wave_sel steps 1,2,3,0 with 4 pulses. key[3] likewise steps wave_a.
- key[2] press at wave_freq=500 -> stays 500, no pulse. Force wave_freq to 999500 via key[1] presses, press key[1] again -> stays 999500, no pulse.
- key[1] bouncing (low 2 cycles, high 1, low 2, high 1, then low steady) -> exactly one increment, after the final steady run of 4 cycles.
- key[1] and key[2] pressed on the same cycle with key[0] -> wave_freq unchanged, wave_sel+1, one pulse.
- AUTO_REPEAT_EN: hold key[1] 60 cycles past debounce -> increments at press, +20, +28, +36, +44, +52, +60 cycles (7 steps). rst_n low mid-hold -> outputs reset asynchronously, repeats stop.
